serial_sub6: RTL and testbench

Bit-serial unsigned subtractor computing a - b, LSB first, one bit per clock through a single one-bit full-adder cell. It is the inverse-direction companion to the team's 6-bit ripple adder: it trades area for latency and gives a start/done handshake for sequential datapaths. Result is a 7-bit two's-complement difference.

---
 rtl/serial_sub6_pkg.sv | 11 +
 rtl/serial_sub6_if.sv | 23 ++
 rtl/oneb_FA.sv | 13 +
 rtl/serial_sub6.sv | 100 ++++++++++
 tb/tb_serial_sub6.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/serial_sub6_pkg.sv
// rtl/serial_sub6_pkg.sv - shared constants and state encoding for serial_sub6
package serial_sub6_pkg;

  localparam int W  = 6;
  localparam int CW = $clog2(W);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_sub6_if.sv
// rtl/serial_sub6_if.sv - start/done handshake and operand/result bus for serial_sub6
interface serial_sub6_if;
  import serial_sub6_pkg::*;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W:0]   diff;

  modport master (
    output start, a, b,
    input  ready, busy, done, diff
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, diff
  );

endinterface

// File: rtl/oneb_FA.sv
// rtl/oneb_FA.sv - one-bit full-adder cell
module oneb_FA (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_sub6.sv
// rtl/serial_sub6.sv - bit-serial unsigned subtractor a - b, LSB first, one bit per clock
module serial_sub6
  import serial_sub6_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  serial_sub6_if.slave  bus
);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  a_sr_q, a_sr_d;
  logic [W-1:0]  b_sr_q, b_sr_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  res_q, res_d;
  logic [W:0]    diff_q, diff_d;
  logic          done_q, done_d;

  logic          fa_sum;
  logic          fa_cout;
  logic          accept;

  // Subtraction as a + ~b + 1: the inverted subtrahend bit feeds the adder, carry presets to 1.
  oneb_FA u_fa (
    .a_i    (a_sr_q[0]),
    .b_i    (~b_sr_q[0]),
    .cin_i  (carry_q),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

  assign bus.ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign bus.busy  = (state_q == ST_RUN);
  assign bus.done  = done_q;
  assign bus.diff  = diff_q;

  assign accept = bus.ready && bus.start;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    carry_d = carry_q;
    res_d   = res_q;
    diff_d  = diff_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = 1'b1;
          count_d = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        res_d   = {fa_sum, res_q[W-1:1]};
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = fa_cout;
        count_d = count_q + 1'b1;
        // Final bit: the missing carry-out is the borrow, i.e. the sign of the result.
        if (count_q == CW'(W - 1)) begin
          diff_d  = {~fa_cout, fa_sum, res_q[W-1:1]};
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      diff_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_sub6.sv
// tb/tb_serial_sub6.sv - self-checking bench for serial_sub6 against an arithmetic reference
module tb_serial_sub6;

  logic clk;
  logic rst_n;
  int   chk_cnt;
  int   err_cnt;

  serial_sub6_if bus ();

  serial_sub6 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_diff(input logic [5:0] x, input logic [5:0] y);
    int d;
    d = int'(x) - int'(y);
    return 7'(d);
  endfunction

  // Entered and left on a falling edge; accept happens at the following rising edge.
  task automatic run_op(input logic [5:0] ta, input logic [5:0] tb, input bit verbose);
    logic [6:0] exp_d;
    logic [6:0] prev_d;
    exp_d  = ref_diff(ta, tb);
    prev_d = bus.diff;
    check_eq("ready_before_start", 32'(bus.ready), 32'd1);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 6'($urandom);
    bus.b     = 6'($urandom);
    @(negedge clk);
    if (verbose) begin
      check_eq("busy_after_accept", 32'(bus.busy), 32'd1);
      check_eq("ready_after_accept", 32'(bus.ready), 32'd0);
    end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check_eq($sformatf("done_k%0d_%0d_%0d", k, ta, tb), 32'(bus.done), 32'(k == 6));
      if (k < 6) check_eq("diff_hold_run", 32'(bus.diff), 32'(prev_d));
      else       check_eq($sformatf("diff_%0d_%0d", ta, tb), 32'(bus.diff), 32'(exp_d));
    end
    check_eq("ready_after_done", 32'(bus.ready), 32'd1);
  endtask

  initial begin
    int dones;
    int off;
    logic [11:0] idx;
    chk_cnt   = 0;
    err_cnt   = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 32'(bus.ready), 32'd1);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_diff", 32'(bus.diff), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(6'd45, 6'd17, 1'b1);
    check_eq("const_45_17", 32'(bus.diff), 32'h1C);
    run_op(6'd5, 6'd9, 1'b1);
    check_eq("const_5_9", 32'(bus.diff), 32'h7C);
    run_op(6'd0, 6'd63, 1'b1);
    check_eq("const_0_63", 32'(bus.diff), 32'h41);
    run_op(6'd63, 6'd0, 1'b1);
    check_eq("const_63_0", 32'(bus.diff), 32'h3F);
    run_op(6'd42, 6'd42, 1'b1);
    check_eq("const_42_42", 32'(bus.diff), 32'h00);

    // Second start while busy must be ignored.
    dones     = 0;
    bus.start = 1'b1;
    bus.a     = 6'd10;
    bus.b     = 6'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (k == 2) begin
        bus.start = 1'b1;
        bus.a     = 6'd1;
        bus.b     = 6'd2;
      end
      if (k == 3) bus.start = 1'b0;
      if (bus.done) dones++;
      if (k == 6) check_eq("ignored_start_diff", 32'(bus.diff), 32'h07);
    end
    check_eq("ignored_start_dones", 32'(dones), 32'd1);
    check_eq("ignored_start_idle", 32'(bus.busy), 32'd0);

    // Start held high: second accept in the DONE cycle, no idle gap.
    bus.start = 1'b1;
    bus.a     = 6'd20;
    bus.b     = 6'd5;
    @(posedge clk);
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      check_eq($sformatf("b2b_done_k%0d", k), 32'(bus.done), 32'((k == 6) || (k == 13)));
      if (k == 6) begin
        check_eq("b2b_first_diff", 32'(bus.diff), 32'h0F);
        bus.a = 6'd5;
        bus.b = 6'd20;
      end
      if (k == 7) check_eq("b2b_no_gap", 32'(bus.busy), 32'd1);
      if (k == 13) begin
        check_eq("b2b_second_diff", 32'(bus.diff), 32'h71);
        bus.start = 1'b0;
      end
    end

    // Reset mid-run aborts without a done.
    bus.start = 1'b1;
    bus.a     = 6'd30;
    bus.b     = 6'd12;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_ready", 32'(bus.ready), 32'd1);
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_diff", 32'(bus.diff), 32'd0);
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
      if (k == 2) rst_n = 1'b1;
    end
    check_eq("abort_no_done", 32'(dones), 32'd0);
    run_op(6'd30, 6'd12, 1'b1);
    check_eq("after_abort_diff", 32'(bus.diff), 32'h12);

    // Every operand pair, visited in a random odd-stride permutation.
    off = int'($urandom_range(0, 4095));
    for (int i = 0; i < 4096; i++) begin
      idx = 12'(i * 2053 + off);
      run_op(idx[11:6], idx[5:0], 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
